// File: rtl/norm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : norm_pkg
// Brief    : Shared types and configuration checks for the norm_shifter block.
// Revision : 1.0 - initial release
// ============================================================================
package norm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int C_WIDTH_DEF       = 32;
  localparam int C_SHIFT_WIDTH_DEF = 5;

  // The binary search only covers every shift amount when WIDTH is a power of two.
  function automatic bit cfg_ok(input int width, input int shift_width);
    return width == (1 << shift_width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shifter
// Brief    : Logarithmic left/right shifter with a programmable fill bit.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_shifter #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic [WIDTH-1:0]       data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_amt,
  input  logic                   dir,        // 0 = left, 1 = right
  input  logic                   shift_val,  // fill bit
  output logic [WIDTH-1:0]       data_out
);

  logic [WIDTH-1:0] w_stage [0:SHIFT_WIDTH];

  assign w_stage[0] = data_in;

  for (genvar i = 0; i < SHIFT_WIDTH; i++) begin : g_stage
    localparam int C_AMT = 1 << i;
    assign w_stage[i+1] = !shift_amt[i] ? w_stage[i] :
                          dir ? {{C_AMT{shift_val}}, w_stage[i][WIDTH-1:C_AMT]} :
                                {w_stage[i][WIDTH-1-C_AMT:0], {C_AMT{shift_val}}};
  end

  assign data_out = w_stage[SHIFT_WIDTH];

endmodule
`default_nettype wire

// File: rtl/norm_shifter.sv
`default_nettype none
// ============================================================================
// Module   : norm_shifter
// Brief    : Multi-cycle normalizer / leading-fill counter, one binary-search
//            step per clock, valid/ready on both sides.
//            Optional macro NORM_SIGNED_EN adds in_signed (strip leading ones).
// Revision : 1.0 - initial release
// ============================================================================
module norm_shifter
  import norm_pkg::*;
#(
  parameter int WIDTH       = C_WIDTH_DEF,
  parameter int SHIFT_WIDTH = C_SHIFT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
`ifdef NORM_SIGNED_EN
  input  logic                   in_signed,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_zero
);

  localparam bit C_CFG_OK = cfg_ok(WIDTH, SHIFT_WIDTH);

  if (!C_CFG_OK) begin : g_cfg_err
    $error("norm_shifter: WIDTH must equal 2**SHIFT_WIDTH");
  end

  state_t                 r_state;
  logic [SHIFT_WIDTH-1:0] r_step;
  logic [SHIFT_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]       r_work;
  logic                   r_pol;
  logic                   r_zero;
  logic                   r_out_valid;

  logic                   w_pol;
  logic [SHIFT_WIDTH-1:0] w_amt;
  logic [WIDTH-1:0]       w_mask;
  logic [WIDTH-1:0]       w_shifted;
  logic                   w_hit;

`ifdef NORM_SIGNED_EN
  assign w_pol = in_signed & in_data[WIDTH-1];
`else
  assign w_pol = 1'b0;
`endif

  assign w_amt  = {{(SHIFT_WIDTH-1){1'b0}}, 1'b1} << r_step;
  // Ones over the top 2**step bits: the window examined this step.
  assign w_mask = ~({WIDTH{1'b1}} >> w_amt);
  assign w_hit  = (((r_work ^ {WIDTH{r_pol}}) & w_mask) == '0);

  barrel_shifter #(
    .WIDTH      (WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_shift (
    .data_in  (r_work),
    .shift_amt(w_amt),
    .dir      (1'b0),
    .shift_val(1'b0),
    .data_out (w_shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_cnt       <= '0;
      r_work      <= '0;
      r_pol       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work  <= in_data;
            r_pol   <= w_pol;
            r_zero  <= (in_data == {WIDTH{w_pol}});
            r_step  <= SHIFT_WIDTH'(SHIFT_WIDTH - 1);
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_hit) begin
            r_work <= w_shifted;
            r_cnt  <= r_cnt | w_amt;
          end
          if (r_step == '0) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_step <= r_step - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign out_data  = r_work;
  assign out_shift = r_cnt;
  assign out_zero  = r_zero;

endmodule
`default_nettype wire
